// File: rtl/key_step_pkg.sv
// Shared types, direction constants and FSM encoding for the key step encoder.
package key_step_pkg;

    typedef logic [2:0] step_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    function automatic step_t popcount4(input logic [3:0] v);
        step_t acc;
        acc = 3'd0;
        for (int i = 0; i < 4; i++) begin
            acc = acc + {2'b00, v[i]};
        end
        return acc;
    endfunction

endpackage

// File: rtl/key_step_encoder_if.sv
// Step command channel: valid/ready handshake plus the drop indication.
interface key_step_encoder_if;
    import key_step_pkg::*;

    logic  cmd_valid;
    logic  cmd_ready;
    logic  cmd_dir;
    step_t cmd_step;
    logic  cmd_dropped;

    modport master (output cmd_valid, output cmd_dir, output cmd_step,
                    output cmd_dropped, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, input cmd_step,
                    input cmd_dropped, output cmd_ready);
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic level,
    output logic fall_strobe
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          strobe_q, strobe_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_comb begin
        level_d  = level_q;
        strobe_d = 1'b0;
        cnt_d    = {CW{1'b0}};
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d  = sync2_q;
                strobe_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            level_q  <= 1'b1;
            strobe_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
        end else begin
            sync1_q  <= key_raw;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level       = level_q;
    assign fall_strobe = strobe_q;
endmodule

// File: rtl/key_step_encoder.sv
// Key front end: debounced presses become single valid/ready step commands.
// Optional auto-repeat while a key is held: define KEY_STEP_AUTOREPEAT_EN.
module key_step_encoder
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
`ifdef KEY_STEP_AUTOREPEAT_EN
    , parameter int REPEAT_DELAY  = 25000000
    , parameter int REPEAT_PERIOD = 12500000
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key0,
    input  logic                  key1,
    input  logic [3:0]            dipswitch,
    key_step_encoder_if.master    cmd
);
    logic [1:0] lvl_s, fall_s, ev_s;
    logic [3:0] dip1_q, dip2_q;
    state_t     state_q, state_d;
    logic       valid_q, dir_q, dir_d, drop_q, drop_d;
    step_t      step_q, step_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
        .clk(clk), .rst_n(rst_n), .key_raw(key0), .level(lvl_s[0]), .fall_strobe(fall_s[0]));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clk(clk), .rst_n(rst_n), .key_raw(key1), .level(lvl_s[1]), .fall_strobe(fall_s[1]));

`ifdef KEY_STEP_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt_q [2];
    logic [RW-1:0] rpt_cnt_d [2];
    logic [1:0]    rpt_first_q, rpt_first_d, rpt_fire_q, rpt_fire_d;

    // Cycles since the last press or repeat; the first interval uses the longer delay.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rpt_cnt_d[k]   = rpt_cnt_q[k];
            rpt_first_d[k] = rpt_first_q[k];
            rpt_fire_d[k]  = 1'b0;
            if (lvl_s[k]) begin
                rpt_cnt_d[k]   = {RW{1'b0}};
                rpt_first_d[k] = 1'b1;
            end else if (fall_s[k]) begin
                rpt_cnt_d[k]   = {{(RW-1){1'b0}}, 1'b1};
                rpt_first_d[k] = 1'b1;
            end else if (rpt_cnt_q[k] >= (rpt_first_q[k] ? DELAY_LAST : PERIOD_LAST)) begin
                rpt_cnt_d[k]   = {RW{1'b0}};
                rpt_first_d[k] = 1'b0;
                rpt_fire_d[k]  = 1'b1;
            end else begin
                rpt_cnt_d[k] = rpt_cnt_q[k] + {{(RW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Auto-repeat timing registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                rpt_cnt_q[k] <= {RW{1'b0}};
            end
            rpt_first_q <= 2'b11;
            rpt_fire_q  <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                rpt_cnt_q[k] <= rpt_cnt_d[k];
            end
            rpt_first_q <= rpt_first_d;
            rpt_fire_q  <= rpt_fire_d;
        end
    end

    assign ev_s = fall_s | rpt_fire_q;
`else
    assign ev_s = fall_s;
`endif

    // Single-slot command FSM; key0 has priority, anything that cannot be held is dropped.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        step_d  = step_q;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev_s[0]) begin
                    state_d = PEND;
                    dir_d   = DIR_UP;
                    step_d  = popcount4(dip2_q);
                    drop_d  = ev_s[1];
                end else if (ev_s[1]) begin
                    state_d = PEND;
                    dir_d   = DIR_DOWN;
                    step_d  = popcount4(dip2_q);
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                drop_d = ev_s[0] | ev_s[1];
                if (cmd.cmd_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = PEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, output registers and dipswitch synchroniser.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            step_q  <= 3'd0;
            drop_q  <= 1'b0;
            dip1_q  <= 4'b1111;
            dip2_q  <= 4'b1111;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == PEND);
            dir_q   <= dir_d;
            step_q  <= step_d;
            drop_q  <= drop_d;
            dip1_q  <= dipswitch;
            dip2_q  <= dip1_q;
        end
    end

    assign cmd.cmd_valid   = valid_q;
    assign cmd.cmd_dir     = dir_q;
    assign cmd.cmd_step    = step_q;
    assign cmd.cmd_dropped = drop_q;
endmodule

// File: tb/tb_key_step_encoder.sv
// Randomised and directed bench for key_step_encoder against a cycle-level behavioural model.
module tb_key_step_encoder;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key0 = 1'b1;
    logic       key1 = 1'b1;
    logic [3:0] dipswitch = 4'b0000;
    logic       ready = 1'b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    key_step_encoder_if cmd_if ();
    assign cmd_if.cmd_ready = ready;

    key_step_encoder #(
        .DEBOUNCE_CYCLES(DEB)
`ifdef KEY_STEP_AUTOREPEAT_EN
        , .REPEAT_DELAY(RD)
        , .REPEAT_PERIOD(RP)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .key0(key0), .key1(key1),
        .dipswitch(dipswitch), .cmd(cmd_if.master)
    );

    always #5 clk = ~clk;

    // Behavioural model: state as it should be just after each clock edge.
    bit         m_pipe1 [2], m_pipe2 [2], m_lvl [2], m_fall [2], m_rpt [2], m_t0_ok [2];
    int         m_run [2], m_t0 [2];
    logic [3:0] m_d1, m_d2;
    bit         m_pend, m_dir, m_drop, m_rst_last;
    int         m_step;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        bit raw [2];
        bit ev [2];
        bit old_lvl;
        raw[0] = key0;
        raw[1] = key1;
        cyc++;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_pipe1[k] = 1; m_pipe2[k] = 1; m_lvl[k] = 1;
                m_fall[k] = 0; m_rpt[k] = 0; m_run[k] = 0; m_t0_ok[k] = 0;
            end
            m_d1 = 4'b1111; m_d2 = 4'b1111;
            m_pend = 0; m_dir = 0; m_step = 0; m_drop = 0;
            m_rst_last = 1;
        end else begin
            m_rst_last = 0;
            for (int k = 0; k < 2; k++) ev[k] = m_fall[k] | m_rpt[k];
            m_drop = 0;
            if (m_pend) begin
                m_drop = ev[0] | ev[1];
                if (ready) m_pend = 0;
            end else if (ev[0] || ev[1]) begin
                m_pend = 1;
                m_dir  = ev[0];
                m_step = $countones(m_d2);
                m_drop = ev[0] & ev[1];
            end
            for (int k = 0; k < 2; k++) begin
                old_lvl   = m_lvl[k];
                m_fall[k] = 0;
                m_rpt[k]  = 0;
                // A level change needs DEB consecutive disagreeing synchronised samples.
                if (m_pipe2[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_lvl[k]  = m_pipe2[k];
                        m_run[k]  = 0;
                        m_fall[k] = !m_lvl[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
`ifdef KEY_STEP_AUTOREPEAT_EN
                if (old_lvl) m_t0_ok[k] = 0;
                else if (m_t0_ok[k] && (cyc - m_t0[k] >= RD) && ((cyc - m_t0[k] - RD) % RP == 0))
                    m_rpt[k] = 1;
                if (m_fall[k]) begin
                    m_t0[k] = cyc;
                    m_t0_ok[k] = 1;
                end
`else
                if (old_lvl) m_t0_ok[k] = 0;
`endif
                m_pipe2[k] = m_pipe1[k];
                m_pipe1[k] = raw[k];
            end
            m_d2 = m_d1;
            m_d1 = dipswitch;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("valid", int'(cmd_if.cmd_valid), int'(m_pend));
        if (m_pend || m_rst_last) begin
            check_eq("dir", int'(cmd_if.cmd_dir), int'(m_dir));
            check_eq("step", int'(cmd_if.cmd_step), m_step);
        end
        check_eq("dropped", int'(cmd_if.cmd_dropped), int'(m_drop));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int n_lat;
    bit found;
    int cd0, cd1, ncmd;

    initial begin
        ticks(3);
        rst_n = 1'b1;
        ticks(3);

        // Single press, latency from the raw edge
        dipswitch = 4'b1011;
        key0 = 1'b0;
        n_lat = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            n_lat++;
            if (cmd_if.cmd_valid) found = 1;
        end
        check_eq("lat_key0", n_lat, 2 + DEB + 1);
        ticks(10);
        key0 = 1'b1;
        ticks(12);

        // Bounce on key1, then a short glitch
        key1 = 1'b0; ticks(2); key1 = 1'b1; ticks(1); key1 = 1'b0; ticks(10);
        key1 = 1'b1; ticks(10);
        key1 = 1'b0; ticks(3); key1 = 1'b1; ticks(15);

        // Backpressure hold with a dropped second press
        ready = 1'b0; dipswitch = 4'b1111;
        key0 = 1'b0; ticks(10); key0 = 1'b1; ticks(10);
        key1 = 1'b0; ticks(10); key1 = 1'b1; ticks(10);
        ready = 1'b1; ticks(4);

        // Simultaneous press, zero step
        dipswitch = 4'b0000;
        key0 = 1'b0; key1 = 1'b0; ticks(10);
        key0 = 1'b1; key1 = 1'b1; ticks(12);

        // Reset during PEND and mid-debounce
        ready = 1'b0; dipswitch = 4'b0110;
        key0 = 1'b0; ticks(9);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        ticks(4); key0 = 1'b1; ticks(8);
        ready = 1'b1;
        key1 = 1'b0; ticks(4);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        ticks(12); key1 = 1'b1; ticks(10);

        // Long hold, counting commands
        dipswitch = 4'b0011;
        key0 = 1'b0;
        ncmd = 0;
        for (int i = 0; i < 2 + DEB + 60; i++) begin
            tick();
            if (cmd_if.cmd_valid) ncmd++;
        end
`ifdef KEY_STEP_AUTOREPEAT_EN
        check_eq("hold_cmds", ncmd, 6);
`else
        check_eq("hold_cmds", ncmd, 1);
`endif
        key0 = 1'b1; ticks(10);

        // Randomised key activity, switches and backpressure
        cd0 = 5; cd1 = 9;
        for (int i = 0; i < 2500; i++) begin
            if (--cd0 <= 0) begin key0 = ~key0; cd0 = $urandom_range(1, 14); end
            if (--cd1 <= 0) begin key1 = ~key1; cd1 = $urandom_range(1, 14); end
            if ($urandom_range(0, 15) == 0) dipswitch = 4'($urandom);
            ready = ($urandom_range(0, 9) < 7);
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
